tm1638_bin2bcd: RTL and testbench
=================================

# tm1638_bin2bcd

Sequential binary-to-BCD converter that sits directly upstream of the TM1638 display driver and produces its eight 4-bit digit inputs from one unsigned binary value. It uses iterative shift-and-add-3 (double dabble), one bit per clock, and updates its digit outputs atomically when a conversion completes, so the display never shows a partial result. An optional leading-zero blanking mask is produced for the display path.

## Interface
- BIN_W, 27: width of the binary input; must satisfy 2^BIN_W > 10^DIGITS - 1.
- DIGITS, 8: number of BCD digits produced; matches the TM1638 driver's digit count.

- clk_50M  input  1  system clock; one clock domain only.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned value; latched on the accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the digits have updated.
- overflow  output  1  set if the last latched value exceeded 10^DIGITS-1; held until the next done.
- digits  output  4*DIGITS  BCD digits; digit 0 (least significant) is at [3:0].
- blank_mask  output  DIGITS  bit i high means digit i is a leading zero (see Configuration).

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: performs the conversion.
  - DONE: publishes the result.
- IDLE:
  - start=1 latches bin into the shift register, clears the BCD accumulator, and loads bit counter = BIN_W.
  - If bin > 10^DIGITS-1, go to DONE with the overflow flag pending.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every accumulator nibble that is ≥ 5.
  - Shift {accumulator, shift register} left by 1.
  - Decrement the counter; when the counter reaches 1, go to DONE on the next edge.
- DONE:
  - Register the accumulator into digits and assert done for one cycle.
  - Update overflow and blank_mask in the same cycle.
  - Return to IDLE.
- Overflow result: digits are all 4'h9 (saturated), overflow=1, blank_mask=0.
- start while busy or in DONE is ignored; there is no queueing.
- bin is don't-care outside the accepting cycle.
- digits, overflow and blank_mask hold their values between conversions.
- Reset at any time:
  - state returns to IDLE;
  - digits=0, overflow=0, blank_mask=0, busy=0, done=0;
  - any in-flight conversion is discarded.
- Arithmetic: the accumulator is 4*DIGITS bits wide. No nibble can exceed 9 after correction because of the overflow pre-check. The threshold 10^DIGITS-1 is a localparam of width BIN_W.

## Timing
- Start accepted at edge N:
  - busy=1 from edge N+1 (SHIFT entered).
  - The last shift occurs at edge N+BIN_W.
  - done=1 and digits valid from edge N+BIN_W+1.
  - Latency is 28 cycles for BIN_W=27.
- Overflow path: DONE is entered at edge N+1 and done is high after edge N+1; latency is 1 cycle.
- busy deasserts in the same cycle done asserts.
- The earliest next accepted start is the cycle after done, so throughput is one conversion per BIN_W+2 cycles.
- Throughput is far above the TM1638 refresh rate. The driver samples digits continuously, and since they change only on done it sees a consistent frame.

## Configuration
- Macro TM1638_BIN2BCD_LZB_EN.
- Defined:
  - In DONE, blank_mask bit i = 1 for each digit i above the most significant nonzero digit.
  - Digit 0 is never blanked (value 0 gives 8'b1111_1110).
  - Computation is combinational on the accumulator, registered at DONE.
- Undefined: blank_mask is tied to all zeros, and no blanking logic is synthesized.

## Structure
- Shared package tm1638_pkg holds:
  - DIGITS_DEFAULT = 8;
  - the 4-bit digit type;
  - the state enumeration (IDLE, SHIFT, DONE);
  - the saturation digit constant 4'h9.
- The TM1638 driver imports the same DIGITS constant.
- Sub-module bcd_add3 is a 4-bit combinational nibble corrector (in ≥ 5 → in+3). It is instantiated DIGITS times in a generate loop.

## Test plan
- After reset:
  - digits=0, busy=0, done=0, overflow=0.
  - bin=0 → done at N+28, digits=32'h0000_0000.
- bin=12_345_678 → digits=32'h1234_5678, overflow=0, done pulse exactly 1 cycle wide.
- Boundary values:
  - bin=99_999_999 → digits=32'h9999_9999, overflow=0.
  - bin=100_000_000 → done at N+1, digits=32'h9999_9999, overflow=1.
- Busy and reset behaviour:
  - A start pulse at N+5 during a conversion of 42 → ignored; a single done; digits=32'h0000_0042.
  - rst asserted at N+10 of a conversion of 305 → IDLE next edge, digits=0, no done.
- With TM1638_BIN2BCD_LZB_EN defined:
  - bin=305 → blank_mask=8'b1111_1000.
  - bin=0 → blank_mask=8'b1111_1110.
- Without the macro: blank_mask=0 for both of the above values.

Source files
------------

// File: rtl/tm1638_bin2bcd_pkg.sv
// Shared TM1638 display-path types and constants: digit count, BCD digit type,
// converter state encoding and the saturation digit shown on overflow.
package tm1638_pkg;

  localparam int DIGITS_DEFAULT = 8;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam bcd_digit_t SAT_DIGIT = 4'h9;

endpackage

// File: rtl/tm1638_bin2bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3
  import tm1638_pkg::*;
(
  input  bcd_digit_t in_i,
  output bcd_digit_t out_o
);

  assign out_o = (in_i >= 4'd5) ? bcd_digit_t'(in_i + 4'd3) : in_i;

endmodule

// File: rtl/tm1638_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the
// TM1638 driver. Define TM1638_BIN2BCD_LZB_EN to build the leading-zero blanking mask.
module tm1638_bin2bcd
  import tm1638_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk_50M,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);

  state_t                 state_q, state_d;
  logic                   load_en, shift_en, pub_en;
  logic [BIN_W-1:0]       sh_q;
  logic [ACC_W-1:0]       acc_q, acc_corr;
  logic [ACC_W+BIN_W-1:0] shift_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_pend_q;
  logic [ACC_W-1:0]       digits_q;
  logic                   done_q, ovf_q;

  always_ff @(posedge clk_50M) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (bin > MAX_VAL) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    load_en  = (state_q == S_IDLE) && start;
    shift_en = (state_q == S_SHIFT);
    pub_en   = (state_q == S_DONE);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (acc_q[4*g +: 4]),
      .out_o (acc_corr[4*g +: 4])
    );
  end

  assign shift_d = {acc_corr, sh_q} << 1;

  // The overflow pre-check guarantees no decade ever exceeds 9 in the accumulator.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= pub_en;
      if (load_en) begin
        sh_q       <= bin;
        acc_q      <= '0;
        cnt_q      <= CNT_W'(BIN_W);
        ovf_pend_q <= (bin > MAX_VAL);
      end else if (shift_en) begin
        {acc_q, sh_q} <= shift_d;
        cnt_q         <= cnt_q - CNT_W'(1);
      end
      if (pub_en) begin
        digits_q <= ovf_pend_q ? {DIGITS{SAT_DIGIT}} : acc_q;
        ovf_q    <= ovf_pend_q;
      end
    end
  end

  assign digits   = digits_q;
  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef TM1638_BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_d, blank_q;
  logic              nz_seen;

  // Digit 0 is never blanked so a zero value still shows a single "0".
  always_comb begin
    blank_d = '0;
    nz_seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz_seen    = nz_seen | (acc_q[4*i +: 4] != 4'h0);
      blank_d[i] = ~nz_seen;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst)         blank_q <= '0;
    else if (pub_en) blank_q <= ovf_pend_q ? '0 : blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_tm1638_bin2bcd.sv
// Directed self-checking bench for tm1638_bin2bcd; expected blank masks follow
// TM1638_BIN2BCD_LZB_EN so the bench matches either build.
module tb_tm1638_bin2bcd;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic        busy, done, overflow;
  logic [31:0] digits;
  logic [7:0]  blank_mask;

  int errors = 0;
  int checks = 0;

  tm1638_bin2bcd dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .digits     (digits),
    .blank_mask (blank_mask)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic logic [7:0] exp_blank(input logic [7:0] lzb_val);
`ifdef TM1638_BIN2BCD_LZB_EN
    return lzb_val;
`else
    return 8'h00;
`endif
  endfunction

  // Starts a conversion from just after an edge; returns cycles from accept edge to done.
  task automatic run(input logic [26:0] v, output int lat, output logic busy_acc);
    start = 1'b1;
    bin   = v;
    @(posedge clk_50M); #1;
    start = 1'b0;
    bin   = 27'h5A5A5A5;
    busy_acc = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk_50M); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    checks++; if (digits !== 32'h0) begin errors++; $display("FAIL reset_digits got %h want 0", digits); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (blank_mask !== 8'h00) begin errors++; $display("FAIL reset_blank got %b want 0", blank_mask); end
    rst = 1'b0;
  endtask

  task automatic test_conv(input logic [26:0] v, input logic [31:0] exp_dig, input logic exp_ovf,
                           input int exp_lat, input logic [7:0] lzb);
    int lat;
    logic busy_acc;
    run(v, lat, busy_acc);
    checks++; if (busy_acc !== 1'b1) begin errors++; $display("FAIL busy_after_accept bin=%0d got %b want 1", v, busy_acc); end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency bin=%0d got %0d want %0d", v, lat, exp_lat); end
    checks++; if (digits !== exp_dig) begin errors++; $display("FAIL digits bin=%0d got %h want %h", v, digits, exp_dig); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL overflow bin=%0d got %b want %b", v, overflow, exp_ovf); end
    checks++; if (blank_mask !== exp_blank(lzb)) begin errors++; $display("FAIL blank bin=%0d got %b want %b", v, blank_mask, exp_blank(lzb)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done bin=%0d got %b want 0", v, busy); end
    @(posedge clk_50M); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width bin=%0d got %b want 0", v, done); end
    repeat (4) @(posedge clk_50M);
    #1;
    checks++; if (digits !== exp_dig || overflow !== exp_ovf) begin
      errors++; $display("FAIL hold bin=%0d got %h/%b want %h/%b", v, digits, overflow, exp_dig, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic busy_acc;
    run(27'd1234, lat, busy_acc);
    checks++; if (digits !== 32'h0000_1234) begin errors++; $display("FAIL b2b_first got %h want 00001234", digits); end
    run(27'd5678, lat, busy_acc);
    checks++; if (lat != 28) begin errors++; $display("FAIL b2b_latency got %0d want 28", lat); end
    checks++; if (digits !== 32'h0000_5678) begin errors++; $display("FAIL b2b_second got %h want 00005678", digits); end
    @(posedge clk_50M); #1;
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    int at = -1;
    start = 1'b1; bin = 27'd42;
    @(posedge clk_50M); #1;
    start = 1'b0; bin = 27'd7;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) start = 1'b1;
      @(posedge clk_50M); #1;
      start = 1'b0;
      if (done === 1'b1) begin ndone++; if (at < 0) at = k; end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
    checks++; if (at != 28) begin errors++; $display("FAIL ignored_latency got %0d want 28", at); end
    checks++; if (digits !== 32'h0000_0042) begin errors++; $display("FAIL ignored_digits got %h want 00000042", digits); end
    checks++; if (blank_mask !== exp_blank(8'b1111_1100)) begin errors++; $display("FAIL ignored_blank got %b want %b", blank_mask, exp_blank(8'b1111_1100)); end
  endtask

  task automatic test_reset_midway();
    int ndone = 0;
    start = 1'b1; bin = 27'd305;
    @(posedge clk_50M); #1;
    start = 1'b0;
    repeat (9) @(posedge clk_50M);
    #1;
    rst = 1'b1;
    @(posedge clk_50M); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (digits !== 32'h0) begin errors++; $display("FAIL midrst_digits got %h want 0", digits); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_50M); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    checks++; if (digits !== 32'h0) begin errors++; $display("FAIL midrst_digits_after got %h want 0", digits); end
  endtask

  initial begin
    test_reset();
    test_conv(27'd0,           32'h0000_0000, 1'b0, 28, 8'b1111_1110);
    test_conv(27'd12_345_678,  32'h1234_5678, 1'b0, 28, 8'b0000_0000);
    test_conv(27'd99_999_999,  32'h9999_9999, 1'b0, 28, 8'b0000_0000);
    test_conv(27'd100_000_000, 32'h9999_9999, 1'b1, 1,  8'b0000_0000);
    test_conv(27'd305,         32'h0000_0305, 1'b0, 28, 8'b1111_1000);
    test_conv(27'd134_217_727, 32'h9999_9999, 1'b1, 1,  8'b0000_0000);
    test_conv(27'd90_807_060,  32'h9080_7060, 1'b0, 28, 8'b0000_0000);
    test_back_to_back();
    test_start_ignored();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
